// File: rtl/tt_pkg.sv
// Shared definitions for the truth table scanner.
// Contents:
//   tt_state_e        - scanner FSM states (IDLE, SCAN, STREAM, DONE)
//   N_IN_DEF          - default number of function inputs
//   SETTLE_DEF        - default settle cycles before f_out is sampled
//   TT_W_DEF          - default table size (2**N_IN_DEF)
//   CNT_W_DEF         - default minterm count width (N_IN_DEF+1)
//   tt_w() / cnt_w()  - the same two sizes for any N_IN
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 1;
  localparam int TT_W_DEF   = 2 ** N_IN_DEF;
  localparam int CNT_W_DEF  = N_IN_DEF + 1;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Minterm index stream between the scanner and its consumer.
// Handshake: the master raises m_valid with m_index/m_last and holds all three
// unchanged until it sees m_ready high on a rising edge; a beat moves exactly
// on an edge where m_valid and m_ready are both high. m_last marks the final
// beat of a scan's stream. The consumer may drive m_ready at any time.
// Ports (signals):
//   m_valid  - index valid (master -> slave)
//   m_ready  - consumer accepts (slave -> master)
//   m_index  - minterm index, N_IN bits (master -> slave)
//   m_last   - final beat marker (master -> slave)
interface truth_table_scanner_if #(
  parameter int N_IN = 4
) ();
  logic            m_valid;
  logic            m_ready;
  logic [N_IN-1:0] m_index;
  logic            m_last;

  modport master (output m_valid, output m_index, output m_last, input m_ready);
  modport slave  (input m_valid, input m_index, input m_last, output m_ready);
endinterface

// File: rtl/tt_minterm_stream.sv
// Walks a captured truth table from index 0 upward and presents every set
// position as one handshake beat, in ascending order.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - high while the scanner is in STREAM; low clears the pointer
//   truth     - the truth table to walk
//   finished  - the beat carrying m_last transfers this cycle
//   m         - minterm stream (master side)
module tt_minterm_stream
  import tt_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2**N_IN-1:0]   truth,
  output logic                 finished,
  truth_table_scanner_if.master m
);
  localparam int TT_W = tt_w(N_IN);

  // One bit wider than an index so ptr+1 past the top position does not wrap.
  logic [N_IN:0]   ptr;
  logic            hit;
  logic            last;
  logic [TT_W-1:0] above;

  always_comb begin
    hit   = truth[ptr[N_IN-1:0]];
    // Any set bit strictly above ptr means this is not the final beat.
    above = truth >> (ptr + 1'b1);
    last  = (above == '0);
  end

  assign m.m_valid = en & hit;
  assign m.m_index = en ? ptr[N_IN-1:0] : '0;
  assign m.m_last  = en & hit & last;
  assign finished  = en & hit & last & m.m_ready;

  // Skip clear positions one per cycle; on a set position hold until accepted.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ptr <= '0;
    end else if (!hit || m.m_ready) begin
      ptr <= ptr + 1'b1;
    end
  end
endmodule

// File: rtl/truth_table_scanner.sv
// Drives every input combination into an external Boolean function, samples
// its output after a settle delay, rebuilds the truth table and minterm
// count, then streams the minterm indices in ascending order.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - begin a scan (sampled only in IDLE)
//   busy       - high in SCAN and STREAM
//   done       - one-cycle pulse when scan and stream are complete
//   f_in       - combination driven to the function under test (MSB = input a)
//   f_out      - function output
//   truth      - truth table, bit i = f(i)
//   count      - number of set bits in truth
//   dbg_state  - current FSM state
//   m          - minterm index stream (master side)
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      f_in,
  input  logic                 f_out,
  output logic [2**N_IN-1:0]   truth,
  output logic [N_IN:0]        count,
  output tt_state_e            dbg_state,
  truth_table_scanner_if.master m
);
  localparam int            TT_W       = tt_w(N_IN);
  localparam int            CNT_W      = cnt_w(N_IN);
  localparam logic [N_IN:0] LAST_IDX   = (N_IN + 1)'(TT_W - 1);
  localparam logic [3:0]    SETTLE_MAX = 4'(SETTLE);

  tt_state_e     state;
  logic [N_IN:0] idx;
  logic [3:0]    settle_cnt;
  logic          stream_en;
  logic          finished;

  assign stream_en = (state == STREAM);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      f_in       <= '0;
      truth      <= '0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            f_in       <= '0;
            truth      <= '0;
            count      <= '0;
            busy       <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          // f_in changes on the same edge idx advances, so at the sampling
          // edge it has been stable for SETTLE+1 edges.
          if (settle_cnt == SETTLE_MAX) begin
            truth[idx[N_IN-1:0]] <= f_out;
            count                <= count + CNT_W'(f_out);
            settle_cnt           <= '0;
            if (idx == LAST_IDX) begin
              // Empty table: nothing to stream, finish straight away.
              if (count == '0 && !f_out) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= STREAM;
              end
            end else begin
              idx  <= idx + 1'b1;
              f_in <= idx[N_IN-1:0] + N_IN'(1);
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        STREAM: begin
          if (finished) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tt_minterm_stream #(.N_IN(N_IN)) u_stream (
    .clk      (clk),
    .rst      (rst),
    .en       (stream_en),
    .truth    (truth),
    .finished (finished),
    .m        (m)
  );
endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;
  import tt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (SETTLE=1) ----------------
  logic        start = 1'b0;
  logic        busy, done, f_out;
  logic [3:0]  f_in;
  logic [15:0] truth;
  logic [4:0]  count;
  tt_state_e   dbg_state;
  int          fsel = 0;
  truth_table_scanner_if #(.N_IN(4)) m_if ();

  truth_table_scanner #(.N_IN(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .f_in(f_in), .f_out(f_out), .truth(truth), .count(count),
    .dbg_state(dbg_state), .m(m_if)
  );

  // ---------------- DUT (SETTLE=3) ----------------
  logic        start3 = 1'b0;
  logic        busy3, done3, f_out3;
  logic [3:0]  f_in3;
  logic [15:0] truth3;
  logic [4:0]  count3;
  tt_state_e   dbg_state3;
  truth_table_scanner_if #(.N_IN(4)) m3_if ();

  truth_table_scanner #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .f_in(f_in3), .f_out(f_out3), .truth(truth3), .count(count3),
    .dbg_state(dbg_state3), .m(m3_if)
  );

  // Function under test: 0 = SOP test function, 1 = constant 0, 2 = constant 1
  function automatic logic fval(input int sel, input logic [3:0] x);
    logic a, b, c, d;
    {a, b, c, d} = x;
    case (sel)
      0: return (~a & ~b & ~c) | (~a & ~b & ~d) | (~a & b & c & d) |
                (a & ~b & c & d) | (a & b & ~c);
      1: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign f_out  = fval(fsel, f_in);
  assign f_out3 = fval(0, f_in3);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];   // {m_last, m_index}
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] et);
    int hi;
    hi = -1;
    for (int i = 0; i < 16; i++) if (et[i]) hi = i;
    for (int i = 0; i < 16; i++)
      if (et[i]) exp_q.push_back({(i == hi), 4'(i)});
  endtask

  // ---------------- monitor ----------------
  logic       prev_stall = 1'b0;
  logic [4:0] prev_beat  = '0;
  always @(negedge clk) begin
    logic [4:0] e;
    if (done) done_cnt++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {m_if.m_valid, m_if.m_last, m_if.m_index}, {1'b1, prev_beat});
      if (m_if.m_valid) chk("valid_only_busy", busy, 1);
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: got idx %0d last %0b, expected no beat",
                   m_if.m_index, m_if.m_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_if.m_last, m_if.m_index}, e);
        end
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_beat  = {m_if.m_last, m_if.m_index};
    end
  end

  // ---------------- ready driver ----------------
  bit         rdy_toggle = 1'b0;
  logic [3:0] rpat = 4'b1001;
  initial begin
    int k;
    k = 0;
    m_if.m_ready = 1'b1;
    m3_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        m_if.m_ready = rpat[k % 4];
        k++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_scan(input int fs, input logic [15:0] et, input int ec,
                          input int escan, input bit re_pulse);
    int n, scan_cyc, done_at;
    bit seen_v, fin, idle_ok;
    fsel = fs;
    push_exp(et);
    done_cnt = 0;
    n = 0; scan_cyc = 0; done_at = 0; seen_v = 0; fin = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && n < 1000) begin
      @(negedge clk);
      n++;
      if (busy && !m_if.m_valid && !seen_v) scan_cyc++;
      if (m_if.m_valid) seen_v = 1;
      if (re_pulse && n == 10) start = 1'b1;
      if (re_pulse && n == 11) start = 1'b0;
      if (done) begin
        done_at = n;
        fin = 1;
        if (re_pulse) start = 1'b1;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: no done after %0d cycles, expected done", n);
    end
    @(negedge clk);
    start = 1'b0;
    idle_ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (busy) idle_ok = 0;
    end
    chk("truth", truth, et);
    chk("count", count, ec);
    chk("scan_cycles", scan_cyc, escan);
    chk("done_pulses", done_cnt, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("idle_after", idle_ok, 1);
    if (ec == 0) chk("done_latency", done_at, escan + 1);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk({tag, "_state"}, dbg_state, IDLE);
    chk({tag, "_outs"}, {f_in, truth, count, busy, done},
        {4'h0, 16'h0, 5'h0, 1'b0, 1'b0});
    chk({tag, "_stream"}, {m_if.m_valid, m_if.m_index, m_if.m_last}, 6'h0);
    #1 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit hit;
    repeat (3) @(negedge clk);
    reset_check("reset");

    // Test function, full speed consumer
    run_scan(0, 16'h3887, 7, 32, 1'b0);
    // Constant 0: no beats, done right after the scan
    run_scan(1, 16'h0000, 0, 32, 1'b0);
    // Constant 1 with stalling consumer
    rdy_toggle = 1'b1;
    run_scan(2, 16'hFFFF, 16, 32, 1'b0);
    rdy_toggle = 1'b0;
    #1 m_if.m_ready = 1'b1;

    // Reset in the middle of the scan, at combination 9
    fsel = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      if (f_in == 4'd9) hit = 1;
    end
    chk("reach_idx9", hit, 1);
    reset_check("rst_scan");
    run_scan(0, 16'h3887, 7, 32, 1'b0);

    // Reset in the middle of the stream with a beat pending
    m_if.m_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      if (m_if.m_valid) hit = 1;
    end
    chk("reach_stream", {hit, m_if.m_index}, {1'b1, 4'd0});
    reset_check("rst_stream");
    m_if.m_ready = 1'b1;
    run_scan(0, 16'h3887, 7, 32, 1'b0);

    // start re-pulsed during SCAN and in the DONE cycle
    run_scan(0, 16'h3887, 7, 32, 1'b1);

    // SETTLE=3 instance: f_in stability and scan length
    begin
      logic [3:0] prev_f;
      int run, scan3, beats3;
      bit fin3, seen3;
      prev_f = f_in3; run = 0; scan3 = 0; beats3 = 0; fin3 = 0; seen3 = 0;
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      n = 0;
      while (!fin3 && n < 500) begin
        @(negedge clk);
        n++;
        if (f_in3 != prev_f) begin
          chk("settle3_stable", (run >= 4), 1);
          run = 1;
          prev_f = f_in3;
        end else begin
          run++;
        end
        if (busy3 && !m3_if.m_valid && !seen3) scan3++;
        if (m3_if.m_valid) seen3 = 1;
        if (m3_if.m_valid && m3_if.m_ready) beats3++;
        if (done3) fin3 = 1;
      end
      chk("settle3_done", fin3, 1);
      chk("settle3_scan", scan3, 64);
      chk("settle3_truth", truth3, 16'h3887);
      chk("settle3_count", count3, 7);
      chk("settle3_beats", beats3, 7);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
